// File: rtl/scarv_cop_palu_padd_pipe.sv
// Two-stage packed (SIMD) add/subtract with per-lane carry-out and multi-precision carry chaining.
// Optional per-lane unsigned saturation is built only when SCARV_COP_PADD_SAT_EN is defined.
module scarv_cop_palu_padd_pipe #(
    parameter int XLEN  = 32,
    parameter int CHAIN = 1
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [2:0]      in_pw,
    input  logic            in_sub,
    input  logic            in_ci,
    input  logic            in_chain,
`ifdef SCARV_COP_PADD_SAT_EN
    input  logic            in_sat,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_c,
    output logic [15:0]     out_co
);

    localparam int HALF = XLEN / 2;

    localparam logic [2:0] SCARV_COP_PW_1  = 3'd0;
    localparam logic [2:0] SCARV_COP_PW_2  = 3'd1;
    localparam logic [2:0] SCARV_COP_PW_4  = 3'd2;
    localparam logic [2:0] SCARV_COP_PW_8  = 3'd3;
    localparam logic [2:0] SCARV_COP_PW_16 = 3'd4;

    function automatic logic [2:0] norm_pw(input logic [2:0] pw);
        logic [2:0] r;
        case (pw)
            SCARV_COP_PW_2, SCARV_COP_PW_4, SCARV_COP_PW_8, SCARV_COP_PW_16: r = pw;
            default: r = SCARV_COP_PW_1;
        endcase
        return r;
    endfunction

    // Lane width minus one: a bit index i starts a lane when (i & mask) == 0.
    function automatic logic [6:0] lane_mask(input logic [2:0] pw);
        logic [6:0] r;
        case (pw)
            SCARV_COP_PW_2:  r = 7'(XLEN / 2 - 1);
            SCARV_COP_PW_4:  r = 7'(XLEN / 4 - 1);
            SCARV_COP_PW_8:  r = 7'(XLEN / 8 - 1);
            SCARV_COP_PW_16: r = 7'(XLEN / 16 - 1);
            default:         r = 7'(XLEN - 1);
        endcase
        return r;
    endfunction

    // Segmented ripple add over half the datapath; returns {per-bit carry-out, sum}.
    function automatic logic [2*HALF-1:0] seg_add(
        input logic [HALF-1:0] a,
        input logic [HALF-1:0] b,
        input logic            cin_first,
        input logic            cin_lane,
        input logic [6:0]      lmask,
        input int              base
    );
        logic            c;
        logic [HALF-1:0] s;
        logic [HALF-1:0] co;
        c = cin_first;
        for (int i = 0; i < HALF; i++) begin
            if (i != 0 && (7'(base + i) & lmask) == 7'd0)
                c = cin_lane;
            s[i]  = a[i] ^ b[i] ^ c;
            co[i] = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            c     = co[i];
        end
        return {co, s};
    endfunction

    function automatic logic [15:0] pick_co(input logic [2:0] pw, input logic [XLEN-1:0] cb);
        logic [15:0] co;
        co = '0;
        case (pw)
            SCARV_COP_PW_2:  for (int k = 0; k < 2; k++)  co[k] = cb[(k + 1) * (XLEN / 2) - 1];
            SCARV_COP_PW_4:  for (int k = 0; k < 4; k++)  co[k] = cb[(k + 1) * (XLEN / 4) - 1];
            SCARV_COP_PW_8:  for (int k = 0; k < 8; k++)  co[k] = cb[(k + 1) * (XLEN / 8) - 1];
            SCARV_COP_PW_16: for (int k = 0; k < 16; k++) co[k] = cb[(k + 1) * (XLEN / 16) - 1];
            default:         co[0] = cb[XLEN-1];
        endcase
        return co;
    endfunction

`ifdef SCARV_COP_PADD_SAT_EN
    // Broadcast each lane's carry-out across every bit of that lane.
    function automatic logic [XLEN-1:0] lane_co_bits(input logic [6:0] lmask, input logic [XLEN-1:0] cb);
        logic [XLEN-1:0] r;
        logic            cur;
        cur = cb[XLEN-1];
        for (int i = XLEN - 1; i >= 0; i--) begin
            if ((7'(i + 1) & lmask) == 7'd0)
                cur = cb[i];
            r[i] = cur;
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] saturate(
        input logic [XLEN-1:0] s,
        input logic [XLEN-1:0] lco,
        input logic            sub
    );
        return sub ? (s & lco) : (s | lco);
    endfunction
`endif

    logic                accept;
    logic                adv;
    logic                vld_p1;
    logic                vld_p2;
    logic                carry_q;

    logic [2:0]          pw_n;
    logic [XLEN-1:0]     b_eff;
    logic [2*HALF-1:0]   lo_r0;
    logic [2*HALF-1:0]   lo_r1;

    logic [HALF-1:0]     lo_s0_p1;
    logic [HALF-1:0]     lo_s1_p1;
    logic [HALF-1:0]     lo_c0_p1;
    logic [HALF-1:0]     lo_c1_p1;
    logic [HALF-1:0]     a_hi_p1;
    logic [HALF-1:0]     b_hi_p1;
    logic [2:0]          pw_p1;
    logic                sub_p1;
    logic                ci_p1;
    logic                chain_p1;
`ifdef SCARV_COP_PADD_SAT_EN
    logic                sat_p1;
`endif

    logic                cin0;
    logic                bnd;
    logic [HALF-1:0]     lo_s;
    logic [HALF-1:0]     lo_c;
    logic [2*HALF-1:0]   hi_r;
    logic [XLEN-1:0]     sum;
    logic [XLEN-1:0]     cbits;
    logic [XLEN-1:0]     res;

    logic [XLEN-1:0]     c_p2;
    logic [15:0]         co_p2;
    logic                msc_p2;

    assign adv      = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || !vld_p2 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage 1: lower half computed for both possible lane-0 carry-ins, since a chained
    // carry may not be known until the predecessor reaches stage 2.
    assign pw_n  = norm_pw(in_pw);
    assign b_eff = in_sub ? ~in_b : in_b;
    assign lo_r0 = seg_add(in_a[HALF-1:0], b_eff[HALF-1:0], 1'b0, in_sub, lane_mask(pw_n), 0);
    assign lo_r1 = seg_add(in_a[HALF-1:0], b_eff[HALF-1:0], 1'b1, in_sub, lane_mask(pw_n), 0);

    always_ff @(posedge g_clk) begin
        if (accept) begin
            lo_s0_p1 <= lo_r0[HALF-1:0];
            lo_c0_p1 <= lo_r0[2*HALF-1:HALF];
            lo_s1_p1 <= lo_r1[HALF-1:0];
            lo_c1_p1 <= lo_r1[2*HALF-1:HALF];
            a_hi_p1  <= in_a[XLEN-1:HALF];
            b_hi_p1  <= b_eff[XLEN-1:HALF];
            pw_p1    <= pw_n;
            sub_p1   <= in_sub;
            ci_p1    <= in_ci;
            chain_p1 <= in_chain;
`ifdef SCARV_COP_PADD_SAT_EN
            sat_p1   <= in_sat;
`endif
        end
    end

    // Stage 2: resolve lane-0 carry (forwarded from stage 2 if the predecessor is still
    // there), select the lower half and finish the upper half.
    always_comb begin
        cin0 = ci_p1;
        if (CHAIN != 0 && chain_p1)
            cin0 = vld_p2 ? msc_p2 : carry_q;
        lo_s  = cin0 ? lo_s1_p1 : lo_s0_p1;
        lo_c  = cin0 ? lo_c1_p1 : lo_c0_p1;
        bnd   = (pw_p1 == SCARV_COP_PW_1) ? lo_c[HALF-1] : sub_p1;
        hi_r  = seg_add(a_hi_p1, b_hi_p1, bnd, sub_p1, lane_mask(pw_p1), HALF);
        sum   = {hi_r[HALF-1:0], lo_s};
        cbits = {hi_r[2*HALF-1:HALF], lo_c};
        res   = sum;
`ifdef SCARV_COP_PADD_SAT_EN
        if (sat_p1)
            res = saturate(sum, lane_co_bits(lane_mask(pw_p1), cbits), sub_p1);
`endif
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            c_p2    <= '0;
            co_p2   <= '0;
            msc_p2  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (adv)
                vld_p1 <= 1'b0;

            if (adv) begin
                vld_p2 <= 1'b1;
                c_p2   <= res;
                co_p2  <= pick_co(pw_p1, cbits);
                msc_p2 <= cbits[XLEN-1];
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end

            if (CHAIN != 0 && vld_p2 && out_ready)
                carry_q <= msc_p2;
        end
    end

    assign out_valid = vld_p2;
    assign out_c     = c_p2;
    assign out_co    = co_p2;

endmodule
